branch_predictor_btb: RTL and testbench

- Parametrised successor to the fixed branch table in the IF stage: a direct-mapped branch target buffer with per-entry saturating direction counters.
- Looked up combinationally every cycle with the fetch PC; produces a predicted next PC.
- Updated from the ID stage when a beq/bne resolves in the comparator; flags mispredicts so IF/ID can be flushed and the PC redirected.
- Keeps saturating performance counters for lookups and mispredicts.

---
 rtl/bp_pkg.sv | 16 +
 rtl/sat_counter_update.sv | 19 +
 rtl/branch_predictor_btb.sv | 114 +++++++++++
 tb/tb_branch_predictor_btb.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared constants for the branch target buffer: direction-counter reset/allocate
// values and prediction-mode encodings.
package bp_pkg;

  localparam int BP_STATIC  = 0;
  localparam int BP_DYNAMIC = 1;

  function automatic int CTR_WEAK_NT(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  function automatic int CTR_WEAK_T(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Combinational next value of a W-bit up/down counter that saturates at 0 and all-ones.
module sat_counter_update #(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = ctr;
    if (inc && !dec && (ctr != '1))
      nxt = ctr + W'(1);
    else if (dec && !inc && (ctr != '0))
      nxt = ctr - W'(1);
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters,
// combinational lookup for IF, update and mispredict detection from ID, perf counters.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int PC_W    = 13,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int MODE    = 1,
  parameter int PERF_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [PC_W-1:0]   lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [PC_W-1:0]   lk_target,
  input  logic              up_valid,
  input  logic [PC_W-1:0]   up_pc,
  input  logic              up_taken,
  input  logic [PC_W-1:0]   up_target,
  input  logic              up_pred_taken,
  input  logic [PC_W-1:0]   up_pred_target,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [PERF_W-1:0] perf_lookups,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_RST   = CTR_W'(CTR_WEAK_NT(CTR_W));
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(CTR_WEAK_T(CTR_W));
  localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(4);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } bp_entry_t;

  bp_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              up_hit;
  logic [CTR_W-1:0]  up_ctr_nxt;
  logic [PERF_W-1:0] perf_lookups_nxt, perf_mispred_nxt;
  logic              unused_pc_bits;

  // Byte-offset bits never reach the table.
  assign unused_pc_bits = ^{lk_pc[1:0], up_pc[1:0]};

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[PC_W-1:IDX_W+2];
  assign up_idx = up_pc[IDX_W+1:2];
  assign up_tag = up_pc[PC_W-1:IDX_W+2];

  assign lk_hit    = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == lk_tag);
  assign lk_taken  = (MODE == BP_DYNAMIC) && lk_hit && btb_q[lk_idx].ctr[CTR_W-1];
  assign lk_target = lk_taken ? btb_q[lk_idx].target : lk_pc + PC_STEP;

  assign up_hit = btb_q[up_idx].valid && (btb_q[up_idx].tag == up_tag);

  assign mispredict  = up_valid &&
                       ((up_taken != up_pred_taken) ||
                        (up_taken && (up_pred_target != up_target)));
  assign redirect_pc = up_taken ? up_target : up_pc + PC_STEP;

  sat_counter_update #(.W(CTR_W)) u_dir_ctr (
    .ctr (btb_q[up_idx].ctr),
    .inc (up_taken),
    .dec (!up_taken),
    .nxt (up_ctr_nxt)
  );

  sat_counter_update #(.W(PERF_W)) u_perf_lookups (
    .ctr (perf_lookups),
    .inc (lk_hit),
    .dec (1'b0),
    .nxt (perf_lookups_nxt)
  );

  sat_counter_update #(.W(PERF_W)) u_perf_mispred (
    .ctr (perf_mispred),
    .inc (mispredict),
    .dec (1'b0),
    .nxt (perf_mispred_nxt)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < ENTRIES; i++)
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RST};
      perf_lookups <= '0;
      perf_mispred <= '0;
    end else begin
      if (up_valid) begin
        if (up_hit) begin
          btb_q[up_idx].ctr <= up_ctr_nxt;
          if (up_taken)
            btb_q[up_idx].target <= up_target;
        end else if (up_taken) begin
          // Allocation evicts whatever aliased into this slot.
          btb_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: up_target, ctr: CTR_ALLOC};
        end
      end
      perf_lookups <= perf_lookups_nxt;
      perf_mispred <= perf_mispred_nxt;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench: two BTB configurations (dynamic 16x2b, static 4x1b with 3-bit perf)
// driven with directed and random stimulus against an array-based reference model.
module tb_branch_predictor_btb;

  localparam int ENT [2] = '{16, 4};
  localparam int CW  [2] = '{2, 1};
  localparam int MD  [2] = '{1, 0};
  localparam int PW  [2] = '{16, 3};

  logic        clk, rst_n;
  logic [12:0] lk_pc, up_pc, up_target, up_pred_target;
  logic        up_valid, up_taken, up_pred_taken;

  logic        d_hit [2];
  logic        d_taken [2];
  logic [12:0] d_target [2];
  logic        d_mis [2];
  logic [12:0] d_redir [2];
  logic [15:0] look0, mis0;
  logic [2:0]  look1, mis1;
  int          p_look [2];
  int          p_mis [2];

  always_comb begin
    p_look[0] = int'(look0);
    p_mis[0]  = int'(mis0);
    p_look[1] = int'(look1);
    p_mis[1]  = int'(mis1);
  end

  branch_predictor_btb #(.PC_W(13), .ENTRIES(16), .CTR_W(2), .MODE(1), .PERF_W(16)) dut0 (
    .CLK(clk), .RST_n(rst_n), .lk_pc(lk_pc), .lk_hit(d_hit[0]), .lk_taken(d_taken[0]),
    .lk_target(d_target[0]), .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken),
    .up_target(up_target), .up_pred_taken(up_pred_taken), .up_pred_target(up_pred_target),
    .mispredict(d_mis[0]), .redirect_pc(d_redir[0]), .perf_lookups(look0), .perf_mispred(mis0)
  );

  branch_predictor_btb #(.PC_W(13), .ENTRIES(4), .CTR_W(1), .MODE(0), .PERF_W(3)) dut1 (
    .CLK(clk), .RST_n(rst_n), .lk_pc(lk_pc), .lk_hit(d_hit[1]), .lk_taken(d_taken[1]),
    .lk_target(d_target[1]), .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken),
    .up_target(up_target), .up_pred_taken(up_pred_taken), .up_pred_target(up_pred_target),
    .mispredict(d_mis[1]), .redirect_pc(d_redir[1]), .perf_lookups(look1), .perf_mispred(mis1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference model: plain integer arrays per configuration.
  bit m_valid [2][16];
  int m_tag [2][16];
  int m_tgt [2][16];
  int m_ctr [2][16];
  int m_look [2];
  int m_mis [2];
  int checks = 0;
  int errors = 0;

  function automatic int m_idx(int d, int pc);
    return (pc / 4) % ENT[d];
  endfunction

  function automatic int m_tagof(int d, int pc);
    return pc / (4 * ENT[d]);
  endfunction

  function automatic bit m_hit(int d, int pc);
    int i = m_idx(d, pc);
    return m_valid[d][i] && (m_tag[d][i] == m_tagof(d, pc));
  endfunction

  function automatic bit m_taken(int d, int pc);
    return (MD[d] == 1) && m_hit(d, pc) && (m_ctr[d][m_idx(d, pc)] >= (1 << (CW[d] - 1)));
  endfunction

  function automatic int m_target(int d, int pc);
    return m_taken(d, pc) ? m_tgt[d][m_idx(d, pc)] : (pc + 4) % 8192;
  endfunction

  function automatic bit m_mispred();
    return up_valid && ((up_taken != up_pred_taken) || (up_taken && (up_pred_target != up_target)));
  endfunction

  function automatic int m_redirect();
    return up_taken ? int'(up_target) : (int'(up_pc) + 4) % 8192;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[d][i] = 1'b0;
        m_tag[d][i]   = 0;
        m_tgt[d][i]   = 0;
        m_ctr[d][i]   = (1 << (CW[d] - 1)) - 1;
      end
      m_look[d] = 0;
      m_mis[d]  = 0;
    end
  endtask

  task automatic m_edge();
    bit mis;
    int lk, up, i, mx;
    mis = m_mispred();
    lk  = int'(lk_pc);
    up  = int'(up_pc);
    for (int d = 0; d < 2; d++) begin
      mx = (1 << PW[d]) - 1;
      i  = m_idx(d, up);
      if (m_hit(d, lk) && m_look[d] < mx) m_look[d]++;
      if (mis && m_mis[d] < mx) m_mis[d]++;
      if (up_valid) begin
        if (m_hit(d, up)) begin
          if (up_taken) begin
            if (m_ctr[d][i] < (1 << CW[d]) - 1) m_ctr[d][i]++;
            m_tgt[d][i] = int'(up_target);
          end else if (m_ctr[d][i] > 0) begin
            m_ctr[d][i]--;
          end
        end else if (up_taken) begin
          m_valid[d][i] = 1'b1;
          m_tag[d][i]   = m_tagof(d, up);
          m_tgt[d][i]   = int'(up_target);
          m_ctr[d][i]   = 1 << (CW[d] - 1);
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) m_edge();
    @(negedge clk);
  endtask

  task automatic drive_up(bit v, int pc, bit t, int tgt, bit pt, int ptgt);
    up_valid       = v;
    up_pc          = 13'(pc);
    up_taken       = t;
    up_target      = 13'(tgt);
    up_pred_taken  = pt;
    up_pred_target = 13'(ptgt);
  endtask

  task automatic test_reset();
    drive_up(1, 'h200, 1, 'h300, 0, 'h204);
    lk_pc = 13'h200;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_up(0, 'h200, 1, 'h300, 0, 'h204);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (d_hit[d] !== 1'b0) begin
        errors++; $display("FAIL rst_discard_hit dut%0d got %0b want 0", d, d_hit[d]);
      end
      checks++;
      if (d_mis[d] !== 1'b0) begin
        errors++; $display("FAIL mis_gated dut%0d got %0b want 0", d, d_mis[d]);
      end
    end
    cyc();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_reset();
    lk_pc = 13'h040;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (d_hit[d] !== 1'b0 || d_taken[d] !== 1'b0 || d_target[d] !== 13'h044) begin
        errors++; $display("FAIL rst_lookup dut%0d got %0b/%0b/%0h want 0/0/44", d, d_hit[d], d_taken[d], d_target[d]);
      end
      checks++;
      if (p_look[d] !== 0 || p_mis[d] !== 0) begin
        errors++; $display("FAIL rst_perf dut%0d got %0d/%0d want 0/0", d, p_look[d], p_mis[d]);
      end
    end
    lk_pc = 13'h1FFE;
    #1;
    checks++;
    if (d_target[0] !== 13'h0002) begin
      errors++; $display("FAIL pc_wrap got %0h want 2", d_target[0]);
    end
    cyc();
  endtask

  task automatic test_allocate();
    drive_up(1, 'h040, 1, 'h100, 0, 'h044);
    lk_pc = 13'h040;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (d_mis[d] !== 1'b1 || d_redir[d] !== 13'h100) begin
        errors++; $display("FAIL alloc_mis dut%0d got %0b/%0h want 1/100", d, d_mis[d], d_redir[d]);
      end
    end
    cyc();
    drive_up(0, 0, 0, 0, 0, 0);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (d_hit[d] !== 1'b1 || d_taken[d] !== m_taken(d, 'h040) || d_target[d] !== 13'(m_target(d, 'h040))) begin
        errors++; $display("FAIL alloc_lookup dut%0d got %0b/%0b/%0h want 1/%0b/%0h", d, d_hit[d], d_taken[d],
                           d_target[d], m_taken(d, 'h040), m_target(d, 'h040));
      end
    end
    checks++;
    if (d_taken[0] !== 1'b1 || d_target[0] !== 13'h100) begin
      errors++; $display("FAIL alloc_dyn got %0b/%0h want 1/100", d_taken[0], d_target[0]);
    end
    cyc();
  endtask

  task automatic test_hysteresis();
    repeat (3) begin
      drive_up(1, 'h040, 1, 'h100, m_taken(0, 'h040), m_target(0, 'h040));
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      drive_up(1, 'h040, 0, 0, m_taken(0, 'h040), m_target(0, 'h040));
      cyc();
      drive_up(0, 0, 0, 0, 0, 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (d_hit[d] !== m_hit(d, 'h040) || d_taken[d] !== m_taken(d, 'h040) || d_target[d] !== 13'(m_target(d, 'h040))) begin
          errors++; $display("FAIL hyst_lookup%0d dut%0d got %0b/%0b/%0h want %0b/%0b/%0h", k, d, d_hit[d], d_taken[d],
                             d_target[d], m_hit(d, 'h040), m_taken(d, 'h040), m_target(d, 'h040));
        end
      end
      checks++;
      if (d_taken[0] !== (k == 0) || d_target[0] !== ((k == 0) ? 13'h100 : 13'h044)) begin
        errors++; $display("FAIL hyst_dyn%0d got %0b/%0h want %0b", k, d_taken[0], d_target[0], k == 0);
      end
    end
  endtask

  task automatic test_aliasing();
    drive_up(1, 'h080, 1, 'h300, 0, 'h084);
    cyc();
    drive_up(0, 0, 0, 0, 0, 0);
    lk_pc = 13'h040;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (d_hit[d] !== 1'b0) begin
        errors++; $display("FAIL alias_evicted dut%0d got %0b want 0", d, d_hit[d]);
      end
    end
    lk_pc = 13'h080;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (d_hit[d] !== 1'b1 || d_target[d] !== 13'(m_target(d, 'h080))) begin
        errors++; $display("FAIL alias_new dut%0d got %0b/%0h want 1/%0h", d, d_hit[d], d_target[d], m_target(d, 'h080));
      end
    end
    cyc();
    drive_up(1, 'h0C0, 0, 0, 0, 'h0C4);
    cyc();
    drive_up(0, 0, 0, 0, 0, 0);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (d_hit[d] !== 1'b1 || d_target[d] !== 13'(m_target(d, 'h080))) begin
        errors++; $display("FAIL alias_nt_miss dut%0d got %0b/%0h want 1/%0h", d, d_hit[d], d_target[d], m_target(d, 'h080));
      end
    end
    checks++;
    if (d_target[0] !== 13'h300) begin
      errors++; $display("FAIL alias_target got %0h want 300", d_target[0]);
    end
    cyc();
  endtask

  task automatic test_collision();
    drive_up(1, 'h040, 1, 'h140, 0, 'h044);
    cyc();
    lk_pc = 13'h040;
    drive_up(1, 'h040, 0, 0, 1, 'h140);
    #1;
    checks++;
    if (d_taken[0] !== 1'b1 || d_target[0] !== 13'h140) begin
      errors++; $display("FAIL coll_old got %0b/%0h want 1/140", d_taken[0], d_target[0]);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (d_mis[d] !== 1'b1 || d_redir[d] !== 13'h044) begin
        errors++; $display("FAIL coll_mis dut%0d got %0b/%0h want 1/44", d, d_mis[d], d_redir[d]);
      end
    end
    cyc();
    drive_up(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (d_taken[0] !== 1'b0 || d_target[0] !== 13'h044) begin
      errors++; $display("FAIL coll_new got %0b/%0h want 0/44", d_taken[0], d_target[0]);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (d_hit[d] !== m_hit(d, 'h040) || d_taken[d] !== m_taken(d, 'h040)) begin
        errors++; $display("FAIL coll_model dut%0d got %0b/%0b want %0b/%0b", d, d_hit[d], d_taken[d],
                           m_hit(d, 'h040), m_taken(d, 'h040));
      end
    end
    cyc();
  endtask

  task automatic test_static_perf();
    int n = 0;
    while (m_mis[1] < 6 && n < 20) begin
      drive_up(1, 'h1000 + 4 * n, 1, 'h500 + 4 * n, 0, 0);
      cyc();
      n++;
    end
    drive_up(0, 0, 0, 0, 0, 0);
    lk_pc = 13'h1000;
    #1;
    checks++;
    if (p_mis[1] !== 6) begin
      errors++; $display("FAIL perf_pre_sat got %0d want 6", p_mis[1]);
    end
    checks++;
    if (d_hit[1] !== m_hit(1, 'h1000) || d_taken[1] !== 1'b0) begin
      errors++; $display("FAIL static_taken got %0b/%0b want %0b/0", d_hit[1], d_taken[1], m_hit(1, 'h1000));
    end
    for (int k = 0; k < 2; k++) begin
      drive_up(1, 'h1800, 1, 'h600, 0, 0);
      cyc();
      drive_up(0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (p_mis[1] !== 7) begin
        errors++; $display("FAIL perf_sat%0d got %0d want 7", k, p_mis[1]);
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (p_mis[d] !== m_mis[d] || p_look[d] !== m_look[d]) begin
          errors++; $display("FAIL perf_model dut%0d got %0d/%0d want %0d/%0d", d, p_look[d], p_mis[d], m_look[d], m_mis[d]);
        end
      end
    end
    checks++;
    if (d_taken[1] !== 1'b0) begin
      errors++; $display("FAIL static_never_taken got %0b want 0", d_taken[1]);
    end
  endtask

  function automatic int pick_pc();
    if ($urandom_range(0, 7) == 0) return 'h1FFC + $urandom_range(0, 3);
    return 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
  endfunction

  task automatic test_random();
    int lp, upc;
    for (int c = 0; c < 400; c++) begin
      lp  = pick_pc();
      upc = pick_pc();
      lk_pc = 13'(lp);
      if ($urandom_range(0, 1) == 1)
        drive_up($urandom_range(0, 3) != 0, upc, 1'($urandom_range(0, 1)), 4 * $urandom_range(0, 2047),
                 m_taken(0, upc), m_target(0, upc));
      else
        drive_up($urandom_range(0, 3) != 0, upc, 1'($urandom_range(0, 1)), 4 * $urandom_range(0, 2047),
                 1'($urandom_range(0, 1)), 4 * $urandom_range(0, 2047));
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (d_hit[d] !== m_hit(d, lp) || d_taken[d] !== m_taken(d, lp) || d_target[d] !== 13'(m_target(d, lp))) begin
          errors++; $display("FAIL rnd_lookup c%0d dut%0d pc %0h got %0b/%0b/%0h want %0b/%0b/%0h", c, d, lp, d_hit[d],
                             d_taken[d], d_target[d], m_hit(d, lp), m_taken(d, lp), m_target(d, lp));
        end
        checks++;
        if (d_mis[d] !== m_mispred() || d_redir[d] !== 13'(m_redirect())) begin
          errors++; $display("FAIL rnd_update c%0d dut%0d got %0b/%0h want %0b/%0h", c, d, d_mis[d], d_redir[d],
                             m_mispred(), m_redirect());
        end
        checks++;
        if (p_look[d] !== m_look[d] || p_mis[d] !== m_mis[d]) begin
          errors++; $display("FAIL rnd_perf c%0d dut%0d got %0d/%0d want %0d/%0d", c, d, p_look[d], p_mis[d],
                             m_look[d], m_mis[d]);
        end
      end
      cyc();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lk_pc = 13'h0;
    drive_up(0, 0, 0, 0, 0, 0);
    m_reset();
    test_reset();
    test_allocate();
    test_hysteresis();
    test_aliasing();
    test_collision();
    test_static_perf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
